// File: rtl/clk_en_sequencer_if.sv
// Control/status bundle for clk_en_sequencer: mode, step button, divisor writes in; enables, state, tick count out.
interface clk_en_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 27,
    parameter int CH_W   = 1
);
    logic [1:0]        mode;
    logic              step_req;
    logic              div_wr;
    logic [CH_W-1:0]   div_ch;
    logic [DIV_W-1:0]  div_val;
    logic [NUM_CH-1:0] clk_en;
    logic [1:0]        state;
    logic [15:0]       tick_count;

    modport master (
        output mode, step_req, div_wr, div_ch, div_val,
        input  clk_en, state, tick_count
    );

    modport slave (
        input  mode, step_req, div_wr, div_ch, div_val,
        output clk_en, state, tick_count
    );
endinterface

// File: rtl/clk_en_sequencer.sv
// Multi-channel clock-enable generator with RUN/STOP/STEP control; clk_en registered, one cycle after wrap or step edge; no backpressure.
// Define CLK_EN_TICK_COUNT_EN to count channel-0 pulses on tick_count (otherwise tied to zero).
module clk_en_sequencer #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 27,
    parameter int DEFAULT_DIV = 100_000_000,
    parameter int CH_W        = 1
) (
    input  logic              clk,
    input  logic              reset,
    clk_en_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_STOP       = 2'd0,
        ST_RUN        = 2'd1,
        ST_STEP_WAIT  = 2'd2,
        ST_STEP_PULSE = 2'd3
    } state_t;

    localparam logic [1:0]       MODE_RUN  = 2'b01;
    localparam logic [1:0]       MODE_STEP = 2'b10;
    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

    state_t                         state_q, state_d;
    logic                           step_q;
    logic                           step_edge;
    logic                           run_go;
    logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   div_q, div_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0][DIV_W-1:0]   term;
    logic [NUM_CH-1:0]              pend_q, pend_d;
    logic [NUM_CH-1:0]              wr_hit;
    logic [NUM_CH-1:0]              wrap;
    logic [NUM_CH-1:0]              clk_en_q, clk_en_d;

    assign step_edge = bus.step_req & ~step_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (bus.mode == MODE_RUN)
                    state_d = ST_RUN;
                else if (bus.mode == MODE_STEP)
                    state_d = ST_STEP_WAIT;
            end
            ST_RUN: begin
                if (bus.mode != MODE_RUN)
                    state_d = (bus.mode == MODE_STEP) ? ST_STEP_WAIT : ST_STOP;
            end
            ST_STEP_WAIT: begin
                if (bus.mode == MODE_RUN)
                    state_d = ST_RUN;
                else if (bus.mode != MODE_STEP)
                    state_d = ST_STOP;
                else if (step_edge)
                    state_d = ST_STEP_PULSE;
            end
            ST_STEP_PULSE: begin
                if (bus.mode == MODE_RUN)
                    state_d = ST_RUN;
                else if (bus.mode == MODE_STEP)
                    state_d = ST_STEP_WAIT;
                else
                    state_d = ST_STOP;
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Counting only happens while RUN is both current and requested, so a mode change swallows a wrap.
    always_comb begin
        run_go   = (state_q == ST_RUN) && (bus.mode == MODE_RUN);
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        term     = '0;
        wr_hit   = '0;
        wrap     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            term[k]   = (div_q[k] > DIV_ONE) ? (div_q[k] - DIV_ONE) : '0;
            wrap[k]   = run_go && (cnt_q[k] == term[k]);
            wr_hit[k] = bus.div_wr && (bus.div_ch == CH_W'(k));
            cnt_d[k]  = (run_go && !wrap[k]) ? (cnt_q[k] + DIV_ONE) : '0;

            if (state_q != ST_RUN) begin
                if (wr_hit[k])
                    div_d[k] = bus.div_val;
                else if (pend_q[k])
                    div_d[k] = shadow_q[k];
                pend_d[k] = 1'b0;
            end else if (wrap[k]) begin
                // The finishing period used the old divisor; the newest write governs the next one.
                if (wr_hit[k])
                    div_d[k] = bus.div_val;
                else if (pend_q[k])
                    div_d[k] = shadow_q[k];
                pend_d[k] = 1'b0;
            end else if (wr_hit[k]) begin
                shadow_d[k] = bus.div_val;
                pend_d[k]   = 1'b1;
            end
        end
        clk_en_d = (state_d == ST_STEP_PULSE) ? {NUM_CH{1'b1}} : wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_STOP;
            step_q   <= 1'b0;
            cnt_q    <= '0;
            div_q    <= {NUM_CH{DIV_RST}};
            shadow_q <= {NUM_CH{DIV_RST}};
            pend_q   <= '0;
            clk_en_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= bus.step_req;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign bus.clk_en = clk_en_q;
    assign bus.state  = state_q;

`ifdef CLK_EN_TICK_COUNT_EN
    logic [15:0] tick_q;

    always_ff @(posedge clk) begin
        if (reset)
            tick_q <= '0;
        else if (clk_en_d[0])
            tick_q <= tick_q + 16'd1;
    end

    assign bus.tick_count = tick_q;
`else
    assign bus.tick_count = 16'd0;
`endif
endmodule

// File: tb/tb_clk_en_sequencer.sv
// Bench for clk_en_sequencer: vector table, directed corner sequences, and random traffic against a cycle model.
module tb_clk_en_sequencer;
    localparam int NCH  = 2;
    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int DDIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    clk_en_sequencer_if #(.NUM_CH(NCH), .DIV_W(DW), .CH_W(CW)) bus_if ();

    clk_en_sequencer #(
        .NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DDIV), .CH_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase = edges elapsed in the current RUN period of each channel.
    int             m_state;
    int             m_phase [NCH];
    int             m_div   [NCH];
    int             m_pval  [NCH];
    bit             m_pend  [NCH];
    bit             m_step_prev;
    logic [NCH-1:0] m_en;
    logic [15:0]    m_tick;

    typedef struct {
        int rst;
        int mode;
        int step;
        int en;
        int st;
    } vec_t;

    vec_t vt [28];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state     = 0;
        m_step_prev = 1'b0;
        m_en        = '0;
        m_tick      = '0;
        for (int k = 0; k < NCH; k++) begin
            m_phase[k] = 0;
            m_div[k]   = DDIV;
            m_pval[k]  = DDIV;
            m_pend[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        int             md;
        int             nxt;
        bit             run_go;
        bit             wr;
        logic [NCH-1:0] pulse;
        md = int'(bus_if.mode);
        if (reset) begin
            model_reset();
            return;
        end
        run_go = (m_state == 1) && (md == 1);
        // Mode picks the destination; a fresh button edge matters only when already waiting in STEP.
        if (md == 1)
            nxt = 1;
        else if (md == 2)
            nxt = (m_state == 2 && bus_if.step_req && !m_step_prev) ? 3 : 2;
        else
            nxt = 0;
        for (int k = 0; k < NCH; k++) begin
            int period = (m_div[k] < 2) ? 1 : m_div[k];
            pulse[k]   = run_go && (m_phase[k] + 1 == period);
            m_phase[k] = (run_go && !pulse[k]) ? m_phase[k] + 1 : 0;
            wr = bus_if.div_wr && (int'(bus_if.div_ch) == k);
            if (m_state != 1) begin
                if (wr) m_div[k] = int'(bus_if.div_val);
                else if (m_pend[k]) m_div[k] = m_pval[k];
                m_pend[k] = 1'b0;
            end else if (pulse[k]) begin
                if (wr) m_div[k] = int'(bus_if.div_val);
                else if (m_pend[k]) m_div[k] = m_pval[k];
                m_pend[k] = 1'b0;
            end else if (wr) begin
                m_pval[k] = int'(bus_if.div_val);
                m_pend[k] = 1'b1;
            end
        end
        m_en        = (nxt == 3) ? {NCH{1'b1}} : pulse;
        m_tick      = m_tick + 16'(m_en[0]);
        m_state     = nxt;
        m_step_prev = bus_if.step_req;
    endtask

    function automatic int exp_tick();
`ifdef CLK_EN_TICK_COUNT_EN
        return int'(m_tick);
`else
        return 0;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_clk_en", int'(bus_if.clk_en), int'(m_en));
        check("model_state", int'(bus_if.state), m_state);
        check("model_tick", int'(bus_if.tick_count), exp_tick());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.mode = 2'b00;
        bus_if.div_wr = 1'b0;
        bus_if.step_req = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        // rst, mode, step, expected clk_en, expected state
        vt = '{
            '{1, 0, 0, 0, 0}, '{1, 1, 0, 0, 0},
            '{0, 1, 0, 0, 1}, '{0, 1, 0, 0, 1}, '{0, 1, 0, 0, 1}, '{0, 1, 0, 0, 1},
            '{0, 1, 0, 3, 1}, '{0, 1, 0, 0, 1}, '{0, 1, 0, 0, 1}, '{0, 1, 0, 0, 1},
            '{0, 1, 0, 3, 1}, '{0, 1, 0, 0, 1}, '{0, 1, 0, 0, 1}, '{0, 1, 0, 0, 1},
            '{0, 1, 0, 3, 1},
            '{0, 2, 0, 0, 2}, '{0, 2, 1, 3, 3}, '{0, 2, 1, 0, 2}, '{0, 2, 1, 0, 2},
            '{0, 2, 1, 0, 2}, '{0, 2, 1, 0, 2}, '{0, 2, 1, 0, 2}, '{0, 2, 1, 0, 2},
            '{0, 2, 1, 0, 2}, '{0, 2, 1, 0, 2}, '{0, 2, 1, 0, 2},
            '{0, 2, 0, 0, 2}, '{0, 0, 0, 0, 0}
        };

        model_reset();
        bus_if.mode     = 2'b00;
        bus_if.step_req = 1'b0;
        bus_if.div_wr   = 1'b0;
        bus_if.div_ch   = '0;
        bus_if.div_val  = '0;

        foreach (vt[i]) begin
            reset           = (vt[i].rst != 0);
            bus_if.mode     = 2'(vt[i].mode);
            bus_if.step_req = (vt[i].step != 0);
            cycle();
            check("vec_clk_en", int'(bus_if.clk_en), vt[i].en);
            check("vec_state", int'(bus_if.state), vt[i].st);
        end

        // Divisor write mid-period takes effect only after the channel's next wrap.
        do_reset();
        bus_if.mode = 2'b01;
        for (int c = 0; c <= 16; c++) begin
            if (c == 6) begin
                bus_if.div_wr  = 1'b1;
                bus_if.div_ch  = 2'd1;
                bus_if.div_val = 8'd2;
            end else begin
                bus_if.div_wr = 1'b0;
            end
            cycle();
            if (c >= 6) begin
                check("shadow_ch0", int'(bus_if.clk_en[0]), int'(c % 4 == 0 && c > 0));
                check("shadow_ch1", int'(bus_if.clk_en[1]), int'(c >= 8 && c % 2 == 0));
            end
        end

        // Divisor of 1 holds the enable high; a write to an out-of-range channel is ignored.
        do_reset();
        bus_if.div_wr = 1'b1; bus_if.div_ch = 2'd0; bus_if.div_val = 8'd1;
        cycle();
        bus_if.div_ch = 2'd2; bus_if.div_val = 8'd7;
        cycle();
        bus_if.div_wr = 1'b0;
        bus_if.mode   = 2'b01;
        for (int c = 0; c <= 12; c++) begin
            cycle();
            if (c >= 1) begin
                check("div1_ch0", int'(bus_if.clk_en[0]), 1);
                check("div1_ch1", int'(bus_if.clk_en[1]), int'(c % 4 == 0));
            end
        end

        // Reset in the last cycle of a period drops the pending pulse and restores default divisors.
        do_reset();
        bus_if.div_wr = 1'b1; bus_if.div_ch = 2'd1; bus_if.div_val = 8'd2;
        cycle();
        bus_if.div_wr = 1'b0;
        bus_if.mode   = 2'b01;
        for (int c = 0; c <= 3; c++) begin
            cycle();
            if (c == 2) check("pre_rst_ch1", int'(bus_if.clk_en), 2);
        end
        reset = 1'b1;
        cycle();
        check("rst_clk_en", int'(bus_if.clk_en), 0);
        check("rst_state", int'(bus_if.state), 0);
        reset = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            cycle();
            if (c == 2) check("post_rst_c2", int'(bus_if.clk_en), 0);
            if (c == 4) check("post_rst_c4", int'(bus_if.clk_en), 3);
        end

        // Five full RUN periods on channel 0.
        do_reset();
        bus_if.mode = 2'b01;
        for (int c = 0; c <= 20; c++) cycle();
`ifdef CLK_EN_TICK_COUNT_EN
        check("tick_5_periods", int'(bus_if.tick_count), 5);
`else
        check("tick_5_periods", int'(bus_if.tick_count), 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 11) == 0) bus_if.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus_if.step_req = ~bus_if.step_req;
            bus_if.div_wr  = ($urandom_range(0, 7) == 0);
            bus_if.div_ch  = 2'($urandom_range(0, 3));
            bus_if.div_val = 8'($urandom_range(0, 6));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
